// File: rtl/priority_event_encoder.sv
// rtl/priority_event_encoder.sv - registered sticky-pending priority encoder with valid/ready output
// Optional build macro: PRIORITY_EVENT_ENCODER_RR_EN selects round-robin priority instead of fixed.

module priority_event_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] evt_i,
  input  logic [N-1:0] mask_i,
  input  logic         clr_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_idx_o,
  input  logic         out_ready_i,
  output logic         ovf_o
);

  logic [N-1:0] r_pending;
  logic         r_out_valid;
  logic [W-1:0] r_out_idx;
  logic         r_ovf;

  logic [N-1:0] w_cand;
  logic         w_any;
  logic [W-1:0] w_win_idx;
  logic         w_load;
  logic         w_take;
  logic [N-1:0] w_take_mask;

  // Events arriving this cycle compete immediately alongside already-pending ones.
  assign w_cand = (r_pending | evt_i) & mask_i;
  assign w_any  = |w_cand;
  assign w_load = !r_out_valid || out_ready_i;
  assign w_take = w_load && w_any;

`ifdef PRIORITY_EVENT_ENCODER_RR_EN
  logic [W-1:0] r_rr_ptr;

  // Round-robin search: descend from rr_ptr-1 with wrap; the first hit on that path wins,
  // so walking the path backwards and overwriting leaves the first hit in place.
  always_comb begin
    int start;
    w_win_idx = '0;
    start = (r_rr_ptr == '0) ? (N - 1) : (int'(r_rr_ptr) - 1);
    for (int i = N - 1; i >= 0; i--) begin
      int pos;
      pos = start - i;
      if (pos < 0) pos = pos + N;
      if (w_cand[pos]) w_win_idx = pos[W-1:0];
    end
  end

  // Pointer follows the last granted source; a clear leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (!clr_i && w_take) begin
      r_rr_ptr <= w_win_idx;
    end
  end
`else
  // Fixed priority: ascending scan so the highest set index is the last written.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_win_idx = i[W-1:0];
    end
  end
`endif

  // One-hot of the source moved into the output slot this cycle (zero if none).
  assign w_take_mask = w_take ? ({{(N-1){1'b0}}, 1'b1} << w_win_idx) : '0;

  // Pending bits, output slot and sticky overflow; clear beats everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_ovf       <= 1'b0;
    end else if (clr_i) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_pending <= (r_pending | evt_i) & ~w_take_mask;
      if (|(evt_i & r_pending & ~w_take_mask)) r_ovf <= 1'b1;
      if (w_load) begin
        r_out_valid <= w_any;
        if (w_any) r_out_idx <= w_win_idx;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_idx_o   = r_out_idx;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_priority_event_encoder.sv
// tb/tb_priority_event_encoder.sv - scoreboard bench for priority_event_encoder (N=8)

module tb_priority_event_encoder;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic [N-1:0] evt_i;
  logic [N-1:0] mask_i;
  logic         clr_i;
  logic         out_valid_o;
  logic [W-1:0] out_idx_o;
  logic         out_ready_i;
  logic         ovf_o;

  int n_checks;
  int n_fails;
  int exp_q[$];

  priority_event_encoder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_i       (evt_i),
    .mask_i      (mask_i),
    .clr_i       (clr_i),
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .out_ready_i (out_ready_i),
    .ovf_o       (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check();
    int e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_idx", int'(out_idx_o), e);
    end
  endtask

  // Handshake is judged on the values that the coming rising edge will see.
  task automatic step();
    if (rst_n && !clr_i && out_valid_o && out_ready_i) sb_pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    evt_i = v;
    step();
    evt_i = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; evt_i = '0; mask_i = 8'hFF; clr_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", int'(out_valid_o), 0);
    check_eq("rst_idx",   int'(out_idx_o),   0);
    check_eq("rst_ovf",   int'(ovf_o),       0);
    rst_n = 1'b1;
    step();

    // 1: reset while a transfer is held and more events are pending
    pulse(8'h10);
    check_eq("t1_loaded_valid", int'(out_valid_o), 1);
    check_eq("t1_loaded_idx",   int'(out_idx_o),   4);
    pulse(8'h41);
    pulse(8'h01);
    check_eq("t1_ovf_before_rst", int'(ovf_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_valid", int'(out_valid_o), 0);
    check_eq("t1_async_idx",   int'(out_idx_o),   0);
    check_eq("t1_async_ovf",   int'(ovf_o),       0);
    step();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t1_idle_after_rst", int'(out_valid_o), 0);
    end

    // 2: burst of two simultaneous events drains highest first, no bubble
    exp_q.push_back(5);
    exp_q.push_back(2);
    pulse(8'h24);
    check_eq("t2_valid_first", int'(out_valid_o), 1);
    step();
    check_eq("t2_valid_second", int'(out_valid_o), 1);
    step();
    check_eq("t2_drained", int'(out_valid_o), 0);

    // 3: backpressure holds the slot while a new event waits in pending
    out_ready_i = 1'b0;
    pulse(8'h04);
    pulse(8'h80);
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_hold_valid", int'(out_valid_o), 1);
      check_eq("t3_hold_idx",   int'(out_idx_o),   2);
      step();
    end
    exp_q.push_back(2);
    exp_q.push_back(7);
    out_ready_i = 1'b1;
    step();
    check_eq("t3_next_idx", int'(out_idx_o), 7);
    step();
    check_eq("t3_drained", int'(out_valid_o), 0);
    check_eq("t3_no_ovf",  int'(ovf_o),       0);

    // 4: masked source stays pending until its mask bit rises
    mask_i = 8'h7F;
    pulse(8'h80);
    step();
    check_eq("t4_masked_idle", int'(out_valid_o), 0);
    mask_i = 8'hFF;
    exp_q.push_back(7);
    step();
    check_eq("t4_unmasked_idx", int'(out_idx_o), 7);
    step();
    check_eq("t4_drained", int'(out_valid_o), 0);

    // 5: overflow on a repeated pending event, then clear
    out_ready_i = 1'b0;
    pulse(8'h01);
    check_eq("t5_slot_idx0", int'(out_idx_o), 0);
    pulse(8'h08);
    check_eq("t5_ovf_single", int'(ovf_o), 0);
    pulse(8'h08);
    check_eq("t5_ovf_set", int'(ovf_o), 1);
    check_eq("t5_slot_kept", int'(out_idx_o), 0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check_eq("t5_clr_valid", int'(out_valid_o), 0);
    check_eq("t5_clr_ovf",   int'(ovf_o),       0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_clr_idle", int'(out_valid_o), 0);
    end

    // 6: two sources firing every cycle expose the priority mode
`ifdef PRIORITY_EVENT_ENCODER_RR_EN
    for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? 7 : 1);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(7);
    exp_q.push_back(1);
`endif
    evt_i = 8'h82;
    repeat (6) step();
    evt_i = '0;
    repeat (4) step();
    check_eq("t6_drained", int'(out_valid_o), 0);
`ifdef PRIORITY_EVENT_ENCODER_RR_EN
    check_eq("t6_ovf_rr", int'(ovf_o), 0);
`else
    check_eq("t6_ovf_fixed", int'(ovf_o), 1);
`endif
    check_eq("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
